// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, funct3, states, ALU/imm/WB selects.
// MULDIV_EN adds the MDU state and the M-extension ALU codes.
package cu_pkg;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_OPIMM  = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
`ifdef MULDIV_EN
      , S_MDU  = 3'd6
`endif
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
   } cls_t;

   typedef logic [4:0] alu_t;
   localparam alu_t ALU_ADD   = 5'd0;
   localparam alu_t ALU_SUB   = 5'd1;
   localparam alu_t ALU_SLL   = 5'd2;
   localparam alu_t ALU_SLT   = 5'd3;
   localparam alu_t ALU_SLTU  = 5'd4;
   localparam alu_t ALU_XOR   = 5'd5;
   localparam alu_t ALU_SRL   = 5'd6;
   localparam alu_t ALU_SRA   = 5'd7;
   localparam alu_t ALU_OR    = 5'd8;
   localparam alu_t ALU_AND   = 5'd9;
   localparam alu_t ALU_PASSB = 5'd10;
   localparam alu_t ALU_MUL   = 5'd11;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // alt selects SUB/SRA (funct7[5]) for the funct3 slots that have a variant.
   function automatic alu_t alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_t r;
      case (f3)
         F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  r = ALU_SLL;
         F3_SLT:  r = ALU_SLT;
         F3_SLTU: r = ALU_SLTU;
         F3_XOR:  r = ALU_XOR;
         F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational classifier: opcode/funct3/funct7 -> class, datapath selects and legality.
// MULDIV_EN makes funct7=0x01 R-type legal and flags it for the MDU.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output cls_t       cls,
   output alu_t       alu_sel,
   output logic [2:0] imm_sel,
   output logic       a_sel,
   output logic       b_sel,
`ifdef MULDIV_EN
   output logic       is_mdu,
`endif
   output logic       legal
);

   always_comb begin
      cls     = C_NONE;
      alu_sel = ALU_ADD;
      imm_sel = IMM_I;
      a_sel   = 1'b0;
      b_sel   = 1'b0;
      legal   = 1'b0;
`ifdef MULDIV_EN
      is_mdu  = 1'b0;
`endif
      case (opcode)
         OP_OP: begin
            cls = C_R;
            if (funct7 == 7'h00) begin
               legal   = 1'b1;
               alu_sel = alu_from_f3(funct3, 1'b0);
            end else if (funct7 == 7'h20 && (funct3 == F3_ADD || funct3 == F3_SR)) begin
               legal   = 1'b1;
               alu_sel = alu_from_f3(funct3, 1'b1);
            end
`ifdef MULDIV_EN
            else if (funct7 == 7'h01) begin
               legal   = 1'b1;
               is_mdu  = 1'b1;
               alu_sel = ALU_MUL + {2'b00, funct3};
            end
`endif
         end
         OP_OPIMM: begin
            cls     = C_I;
            b_sel   = 1'b1;
            alu_sel = alu_from_f3(funct3, funct3 == F3_SR && funct7[5]);
            if (funct3 == F3_SLL)     legal = (funct7 == 7'h00);
            else if (funct3 == F3_SR) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            else                      legal = 1'b1;
         end
         OP_LOAD: begin
            cls   = C_LOAD;
            b_sel = 1'b1;
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
         end
         OP_STORE: begin
            cls     = C_STORE;
            b_sel   = 1'b1;
            imm_sel = IMM_S;
            legal   = funct3 inside {F3_B, F3_H, F3_W};
         end
         OP_BRANCH: begin
            cls     = C_BRANCH;
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_B;
            legal   = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
         end
         OP_JAL: begin
            cls     = C_JAL;
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_J;
            legal   = 1'b1;
         end
         OP_JALR: begin
            cls   = C_JALR;
            b_sel = 1'b1;
            legal = (funct3 == 3'b000);
         end
         OP_LUI: begin
            cls     = C_LUI;
            b_sel   = 1'b1;
            imm_sel = IMM_U;
            alu_sel = ALU_PASSB;
            legal   = 1'b1;
         end
         OP_AUIPC: begin
            cls     = C_AUIPC;
            a_sel   = 1'b1;
            b_sel   = 1'b1;
            imm_sel = IMM_U;
            legal   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with illegal/timeout traps.
// Define MULDIV_EN to add the MDU state and the mdu_start/mdu_done handshake.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned ALUSEL_W    = 4,
   parameter int unsigned IMMSEL_W    = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         inst,
   input  logic                BrEq,
   input  logic                BrLt,
   input  logic                MemReady,
   output logic                MemReq,
   output logic                MemRW,
   output logic                PCSel,
   output logic                PCWEn,
   output logic                IRWEn,
   output logic                OldPCWEn,
   output logic                RegWEn,
   output logic                BrUn,
   output logic                ASel,
   output logic                BSel,
   output logic [IMMSEL_W-1:0] ImmSel,
   output logic [ALUSEL_W-1:0] ALUSel,
   output logic [1:0]          WBSel,
   output logic                illegal,
   output logic                bus_err,
`ifdef MULDIV_EN
   output logic                mdu_start,
   input  logic                mdu_done,
`endif
   output logic [2:0]          state_o
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        illegal_q, illegal_d;
   logic        bus_err_q, bus_err_d;
   logic        taken;
   logic        unused_ir_bits;

   cls_t        cls;
   alu_t        dec_alu;
   logic [2:0]  dec_imm;
   logic        dec_a, dec_b, dec_legal;
`ifdef MULDIV_EN
   logic        dec_mdu;
   logic        mdu_start_q, mdu_start_d;
`endif

   cu_decoder u_dec (
      .opcode  (ir_q[6:2]),
      .funct3  (ir_q[14:12]),
      .funct7  (ir_q[31:25]),
      .cls     (cls),
      .alu_sel (dec_alu),
      .imm_sel (dec_imm),
      .a_sel   (dec_a),
      .b_sel   (dec_b),
`ifdef MULDIV_EN
      .is_mdu  (dec_mdu),
`endif
      .legal   (dec_legal)
   );

   assign unused_ir_bits = ^{ir_q[1:0], ir_q[11:7], ir_q[24:15]};

   always_comb begin
      case (ir_q[14:12])
         F3_BEQ:           taken = BrEq;
         F3_BNE:           taken = ~BrEq;
         F3_BLT, F3_BLTU:  taken = BrLt;
         F3_BGE, F3_BGEU:  taken = ~BrLt;
         default:          taken = 1'b0;
      endcase
   end

   // Outputs are forced to their reset values while rst_n is low so an
   // in-flight MEM request drops without waiting for a clock edge.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      MemReq    = 1'b0;
      MemRW     = 1'b0;
      PCSel     = 1'b0;
      PCWEn     = 1'b0;
      IRWEn     = 1'b0;
      OldPCWEn  = 1'b0;
      RegWEn    = 1'b0;
      BrUn      = 1'b0;
      ASel      = 1'b0;
      BSel      = 1'b0;
      ImmSel    = IMMSEL_W'(IMM_I);
      ALUSel    = ALUSEL_W'(ALU_ADD);
      WBSel     = WB_ALU;
      if (rst_n) begin
         if (state_q inside {S_EXEC, S_MEM, S_WB
`ifdef MULDIV_EN
                             , S_MDU
`endif
                             }) begin
            ASel   = dec_a;
            BSel   = dec_b;
            ImmSel = IMMSEL_W'(dec_imm);
            ALUSel = ALUSEL_W'(dec_alu);
         end
         case (state_q)
            S_FETCH: begin
               MemReq = 1'b1;
               if (MemReady) begin
                  IRWEn    = 1'b1;
                  OldPCWEn = 1'b1;
                  PCWEn    = 1'b1;
                  ir_d     = inst;
                  cnt_d    = '0;
                  state_d  = S_DECODE;
               end else if (cnt_q == TIMEOUT) begin
                  bus_err_d = 1'b1;
                  state_d   = S_TRAP;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_DECODE: begin
               if (dec_legal) begin
                  state_d = S_EXEC;
               end else begin
                  illegal_d = 1'b1;
                  state_d   = S_TRAP;
               end
            end
            S_EXEC: begin
               case (cls)
                  C_BRANCH: begin
                     BrUn    = ir_q[13];
                     PCWEn   = taken;
                     PCSel   = taken;
                     state_d = S_FETCH;
                  end
                  C_JAL, C_JALR: begin
                     PCWEn   = 1'b1;
                     PCSel   = 1'b1;
                     state_d = S_WB;
                  end
                  C_LOAD, C_STORE: state_d = S_MEM;
                  default: begin
                     state_d = S_WB;
`ifdef MULDIV_EN
                     if (dec_mdu) state_d = S_MDU;
`endif
                  end
               endcase
            end
            S_MEM: begin
               MemReq = 1'b1;
               MemRW  = (cls == C_STORE);
               if (MemReady) begin
                  cnt_d   = '0;
                  state_d = (cls == C_STORE) ? S_FETCH : S_WB;
               end else if (cnt_q == TIMEOUT) begin
                  bus_err_d = 1'b1;
                  state_d   = S_TRAP;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_WB: begin
               RegWEn  = 1'b1;
               WBSel   = (cls == C_LOAD) ? WB_MEM :
                         (cls == C_JAL || cls == C_JALR) ? WB_PC4 : WB_ALU;
               state_d = S_FETCH;
            end
`ifdef MULDIV_EN
            S_MDU: begin
               if (mdu_done) state_d = S_WB;
            end
`endif
            S_TRAP: ;
            default: state_d = S_FETCH;
         endcase
      end
`ifdef MULDIV_EN
      mdu_start_d = (state_q == S_EXEC) && (state_d == S_MDU);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         ir_q        <= 32'h0000_0013;
         cnt_q       <= '0;
         illegal_q   <= 1'b0;
         bus_err_q   <= 1'b0;
`ifdef MULDIV_EN
         mdu_start_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         cnt_q       <= cnt_d;
         illegal_q   <= illegal_d;
         bus_err_q   <= bus_err_d;
`ifdef MULDIV_EN
         mdu_start_q <= mdu_start_d;
`endif
      end
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state_o = state_q;
`ifdef MULDIV_EN
   assign mdu_start = mdu_start_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected control vectors are queued
// with their stimulus and compared one cycle at a time.
module tb_multicycle_control_unit;

   logic        clk, rst_n;
   logic [31:0] inst;
   logic        BrEq, BrLt, MemReady;
   logic        MemReq, MemRW, PCSel, PCWEn, IRWEn, OldPCWEn, RegWEn, BrUn, ASel, BSel;
   logic [2:0]  ImmSel;
   logic [3:0]  ALUSel;
   logic [1:0]  WBSel;
   logic        illegal, bus_err;
   logic [2:0]  state_o;
`ifdef MULDIV_EN
   logic        mdu_start;
   logic        mdu_done;
   assign mdu_done = 1'b0;
`endif

   multicycle_control_unit #(.MEM_TIMEOUT(16), .ALUSEL_W(4), .IMMSEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .MemReady(MemReady),
      .MemReq(MemReq), .MemRW(MemRW), .PCSel(PCSel), .PCWEn(PCWEn), .IRWEn(IRWEn),
      .OldPCWEn(OldPCWEn), .RegWEn(RegWEn), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
      .ImmSel(ImmSel), .ALUSel(ALUSel), .WBSel(WBSel), .illegal(illegal), .bus_err(bus_err),
`ifdef MULDIV_EN
      .mdu_start(mdu_start), .mdu_done(mdu_done),
`endif
      .state_o(state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [2:0] st;
      logic       mreq, mrw, pcwen, pcsel, irwen, oldpc, regwen, brun, asel, bsel;
      logic [2:0] imm;
      logic [3:0] alu;
      logic [1:0] wb;
      logic       ill, berr;
   } obs_t;

   typedef struct {
      logic  mr;
      logic  beq;
      logic  blt;
      obs_t  exp;
      string tag;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t observe();
      obs_t o;
      o.st = state_o; o.mreq = MemReq; o.mrw = MemRW; o.pcwen = PCWEn; o.pcsel = PCSel;
      o.irwen = IRWEn; o.oldpc = OldPCWEn; o.regwen = RegWEn; o.brun = BrUn;
      o.asel = ASel; o.bsel = BSel; o.imm = ImmSel; o.alu = ALUSel; o.wb = WBSel;
      o.ill = illegal; o.berr = bus_err;
      return o;
   endfunction

   function automatic obs_t mk(input logic [2:0] st);
      obs_t e;
      e = '0;
      e.st = st;
      e.wb = 2'd1;
      return e;
   endfunction

   function automatic obs_t dp(input logic [2:0] st, input logic a, input logic b,
                               input logic [2:0] imm, input logic [3:0] alu);
      obs_t e;
      e = mk(st);
      e.asel = a; e.bsel = b; e.imm = imm; e.alu = alu;
      return e;
   endfunction

   function automatic obs_t fetch_wait();
      obs_t e;
      e = mk(3'd0);
      e.mreq = 1'b1;
      return e;
   endfunction

   function automatic obs_t fetch_ok();
      obs_t e;
      e = fetch_wait();
      e.irwen = 1'b1; e.oldpc = 1'b1; e.pcwen = 1'b1;
      return e;
   endfunction

   task automatic push(input string tag, input logic mr, input logic beq, input logic blt,
                       input obs_t e);
      txn_t t;
      t.mr = mr; t.beq = beq; t.blt = blt; t.exp = e; t.tag = tag;
      sb.push_back(t);
   endtask

   task automatic apply_next(output txn_t t, output obs_t got);
      t = sb.pop_front();
      @(negedge clk);
      MemReady = t.mr;
      BrEq     = t.beq;
      BrLt     = t.blt;
      #1 got = observe();
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      MemReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      obs_t got;
      rst_n = 1'b0; MemReady = 1'b1; BrEq = 1'b0; BrLt = 1'b0; inst = 32'h0;
      #2 got = observe();
      checks++;
      if (got !== mk(3'd0)) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", got, mk(3'd0));
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; MemReady = 1'b0;
      #1 got = observe();
      checks++;
      if (got !== fetch_wait()) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", got, fetch_wait());
      end
   endtask

   task automatic test_add();
      txn_t t; obs_t got, w;
      inst = 32'h002081B3;
      w = dp(3'd4, 1'b0, 1'b0, 3'd0, 4'd0); w.regwen = 1'b1;
      push("add_fetch", 1'b1, 1'b0, 1'b0, fetch_ok());
      push("add_decode", 1'b1, 1'b0, 1'b0, mk(3'd1));
      push("add_exec", 1'b1, 1'b0, 1'b0, dp(3'd2, 1'b0, 1'b0, 3'd0, 4'd0));
      push("add_wb", 1'b1, 1'b0, 1'b0, w);
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
   endtask

   task automatic test_alu_ops();
      txn_t t; obs_t got, w;
      logic [31:0] ins [6] = '{32'h402081B3, 32'h4020D1B3, 32'h0020F1B3, 32'h0020B1B3, 32'h0050C193, 32'h123450B7};
      logic [3:0]  alu [6] = '{4'd1, 4'd7, 4'd9, 4'd4, 4'd5, 4'd10};
      logic        bs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  im  [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
      for (int i = 0; i < 6; i++) begin
         inst = ins[i];
         w = dp(3'd4, 1'b0, bs[i], im[i], alu[i]); w.regwen = 1'b1;
         push($sformatf("alu%0d_fetch", i), 1'b1, 1'b0, 1'b0, fetch_ok());
         push($sformatf("alu%0d_decode", i), 1'b0, 1'b0, 1'b0, mk(3'd1));
         push($sformatf("alu%0d_exec", i), 1'b1, 1'b0, 1'b0, dp(3'd2, 1'b0, bs[i], im[i], alu[i]));
         push($sformatf("alu%0d_wb", i), 1'b0, 1'b0, 1'b0, w);
         while (sb.size() != 0) begin
            apply_next(t, got);
            checks++;
            if (got !== t.exp) begin
               errors++;
               $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
            end
         end
      end
   endtask

   task automatic test_load();
      txn_t t; obs_t got, m, w;
      inst = 32'h0080A283;
      m = dp(3'd3, 1'b0, 1'b1, 3'd0, 4'd0); m.mreq = 1'b1;
      w = dp(3'd4, 1'b0, 1'b1, 3'd0, 4'd0); w.regwen = 1'b1; w.wb = 2'd0;
      push("lw_fetch", 1'b1, 1'b0, 1'b0, fetch_ok());
      push("lw_decode", 1'b0, 1'b0, 1'b0, mk(3'd1));
      push("lw_exec", 1'b0, 1'b0, 1'b0, dp(3'd2, 1'b0, 1'b1, 3'd0, 4'd0));
      for (int i = 0; i < 3; i++) push("lw_mem_wait", 1'b0, 1'b0, 1'b0, m);
      push("lw_mem_ready", 1'b1, 1'b0, 1'b0, m);
      push("lw_wb", 1'b1, 1'b0, 1'b0, w);
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
   endtask

   task automatic test_store();
      txn_t t; obs_t got, m;
      inst = 32'h0020A023;
      m = dp(3'd3, 1'b0, 1'b1, 3'd1, 4'd0); m.mreq = 1'b1; m.mrw = 1'b1;
      push("sw_fetch", 1'b1, 1'b0, 1'b0, fetch_ok());
      push("sw_decode", 1'b1, 1'b0, 1'b0, mk(3'd1));
      push("sw_exec", 1'b1, 1'b0, 1'b0, dp(3'd2, 1'b0, 1'b1, 3'd1, 4'd0));
      push("sw_mem", 1'b1, 1'b0, 1'b0, m);
      push("sw_next_fetch", 1'b0, 1'b0, 1'b0, fetch_wait());
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
   endtask

   task automatic test_branch();
      txn_t t; obs_t got, e;
      logic [31:0] ins [3] = '{32'h00208463, 32'h00208463, 32'h0020E463};
      logic        beq [3] = '{1'b1, 1'b0, 1'b0};
      logic        blt [3] = '{1'b0, 1'b1, 1'b1};
      logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
      logic        un  [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         inst = ins[i];
         e = dp(3'd2, 1'b1, 1'b1, 3'd2, 4'd0);
         e.pcwen = tk[i]; e.pcsel = tk[i]; e.brun = un[i];
         push($sformatf("br%0d_fetch", i), 1'b1, 1'b0, 1'b0, fetch_ok());
         push($sformatf("br%0d_decode", i), 1'b1, 1'b0, 1'b0, mk(3'd1));
         push($sformatf("br%0d_exec", i), 1'b0, beq[i], blt[i], e);
         while (sb.size() != 0) begin
            apply_next(t, got);
            checks++;
            if (got !== t.exp) begin
               errors++;
               $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
            end
         end
      end
   endtask

   task automatic test_jal();
      txn_t t; obs_t got, e, w;
      inst = 32'h008000EF;
      e = dp(3'd2, 1'b1, 1'b1, 3'd4, 4'd0); e.pcwen = 1'b1; e.pcsel = 1'b1;
      w = dp(3'd4, 1'b1, 1'b1, 3'd4, 4'd0); w.regwen = 1'b1; w.wb = 2'd2;
      push("jal_fetch", 1'b1, 1'b0, 1'b0, fetch_ok());
      push("jal_decode", 1'b0, 1'b0, 1'b0, mk(3'd1));
      push("jal_exec", 1'b0, 1'b0, 1'b0, e);
      push("jal_wb", 1'b0, 1'b0, 1'b0, w);
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
   endtask

   task automatic test_illegal();
      txn_t t; obs_t got, tr;
      logic [31:0] ins [3] = '{32'h0000007F, 32'h020081B3, 32'h402091B3};
      int          len [3] = '{20, 3, 3};
      tr = mk(3'd5); tr.ill = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_reset();
         inst = ins[i];
         push($sformatf("ill%0d_fetch", i), 1'b1, 1'b0, 1'b0, fetch_ok());
         push($sformatf("ill%0d_decode", i), 1'b1, 1'b0, 1'b0, mk(3'd1));
         for (int k = 0; k < len[i]; k++)
            push($sformatf("ill%0d_trap", i), 1'($urandom_range(0, 1)), 1'b1, 1'b1, tr);
         while (sb.size() != 0) begin
            apply_next(t, got);
            checks++;
            if (got !== t.exp) begin
               errors++;
               $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
            end
         end
      end
   endtask

   task automatic test_timeout();
      txn_t t; obs_t got, tr;
      apply_reset();
      inst = 32'h002081B3;
      tr = mk(3'd5); tr.berr = 1'b1;
      for (int k = 1; k <= 17; k++) push($sformatf("to_wait%0d", k), 1'b0, 1'b0, 1'b0, fetch_wait());
      for (int k = 0; k < 3; k++) push("to_trap", 1'b1, 1'b0, 1'b0, tr);
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      txn_t t; obs_t got, m;
      apply_reset();
      inst = 32'h0020A023;
      m = dp(3'd3, 1'b0, 1'b1, 3'd1, 4'd0); m.mreq = 1'b1; m.mrw = 1'b1;
      push("rmm_fetch", 1'b1, 1'b0, 1'b0, fetch_ok());
      push("rmm_decode", 1'b0, 1'b0, 1'b0, mk(3'd1));
      push("rmm_exec", 1'b0, 1'b0, 1'b0, dp(3'd2, 1'b0, 1'b1, 3'd1, 4'd0));
      push("rmm_mem", 1'b0, 1'b0, 1'b0, m);
      while (sb.size() != 0) begin
         apply_next(t, got);
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t.tag, got, got.st, t.exp, t.exp.st);
         end
      end
      #1 rst_n = 1'b0;
      #1 got = observe();
      checks++;
      if (got !== mk(3'd0)) begin
         errors++;
         $display("FAIL rmm_async_abort: got %h expected %h", got, mk(3'd0));
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 got = observe();
      checks++;
      if (got !== fetch_wait()) begin
         errors++;
         $display("FAIL rmm_after_release: got %h expected %h", got, fetch_wait());
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_ops();
      test_load();
      test_store();
      test_branch();
      test_jal();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
      $fatal(1, "watchdog");
   end

endmodule
